// File: rtl/cbus_burst_responder.sv
// Memory-side burst responder for the cache refill/writeback bus.
// Optional random response stalls are enabled by defining BURST_RESP_STALL_EN.
module cbus_burst_responder #(
  parameter int BURST_NUM = 16,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic                         req_is_write,
  input  logic [31:0]                  req_addr,
  input  logic [$clog2(BURST_NUM)-1:0] req_len,
  input  logic [7:0]                   req_strobe,
  input  logic [63:0]                  req_data,
  output logic                         resp_ready,
  output logic                         resp_last,
  output logic [63:0]                  resp_data
);
  localparam int LEN_W = $clog2(BURST_NUM);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d, idx;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic             wr_q, wr_d, we, stall;
  logic [3:0]       lat_q, lat_d;
  logic [63:0]      mem [MEM_WORDS];
  logic             unused_addr;

  assign unused_addr = ^{req_addr[31:IDX_W+3], req_addr[2:0]};

`ifdef BURST_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (state_q == BURST) && (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wr_q    <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wr_d       = wr_q;
    lat_d      = lat_q;
    resp_ready = 1'b0;
    resp_last  = 1'b0;
    resp_data  = '0;
    we         = 1'b0;
    idx        = base_q + IDX_W'(beat_q);

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d = req_addr[IDX_W+2:3];
          len_d  = req_len;
          wr_d   = req_is_write;
          beat_d = '0;
          if (LATENCY == 0) begin
            state_d = BURST;
          end else begin
            state_d = WAIT;
            lat_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        // Leaving on the decrement that reaches zero gives exactly LATENCY idle cycles.
        if (!req_valid) begin
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
          if (lat_q == 4'd1) state_d = BURST;
        end
      end
      BURST: begin
        if (!req_valid) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (!stall) begin
          resp_ready = 1'b1;
          resp_last  = (beat_q == len_q);
          resp_data  = wr_q ? '0 : mem[idx];
          we         = wr_q;
          if (beat_q == len_q) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset masks the current beat so a mid-burst reset neither responds nor writes.
    if (reset) begin
      resp_ready = 1'b0;
      resp_last  = 1'b0;
      resp_data  = '0;
      we         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (req_strobe[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_cbus_burst_responder.sv
// Self-checking bench for cbus_burst_responder against a word-array reference model.
module tb_cbus_burst_responder;
  localparam int LAT = 1;
  localparam int MW  = 4096;
  localparam int BN  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_is_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_ready;
  logic        resp_last;
  logic [63:0] resp_data;

  int errors = 0;
  int checks = 0;
  logic [63:0] model [MW];

  always #5 clk = ~clk;

  cbus_burst_responder #(
    .BURST_NUM(BN),
    .MEM_WORDS(MW),
    .LATENCY  (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_is_write(req_is_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_strobe  (req_strobe),
    .req_data    (req_data),
    .resp_ready  (resp_ready),
    .resp_last   (resp_last),
    .resp_data   (resp_data)
  );

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Drives one burst as an initiator and checks every cycle against the model.
  // abort_after >= 0 drops req_valid after that beat; reset_at >= 0 asserts reset during that beat.
  task automatic do_burst(input bit wr, input logic [31:0] addr, input int len,
                          input logic [7:0] strb, input bit rnd, input logic [63:0] dbase,
                          input int abort_after, input int reset_at, output int total,
                          output int beats);
    logic [63:0] wd [BN];
    logic [7:0]  ws [BN];
    int base, idx, cyc;
    bit done;
    base = int'(addr[14:3]);
    for (int i = 0; i < BN; i++) begin
      wd[i] = rnd ? {$urandom, $urandom} : dbase + 64'(i);
      ws[i] = rnd ? 8'($urandom) : strb;
    end
    beats = 0; cyc = 0; done = 1'b0;
    req_valid = 1'b1; req_is_write = wr; req_addr = addr; req_len = 4'(len);
    req_strobe = ws[0]; req_data = wd[0];
    while (!done && cyc < 200) begin
      @(negedge clk);
      idx = (base + beats) % MW;
      if (resp_ready) begin
        checks++;
        if (cyc < LAT + 1) begin
          $display("FAIL early_ready: ready at cycle %0d, required no earlier than %0d", cyc, LAT + 1);
          errors++;
        end
        checks++;
        if (resp_last !== (beats == len)) begin
          $display("FAIL last: beat %0d got %b exp %b", beats, resp_last, beats == len);
          errors++;
        end
        checks++;
        if (resp_data !== (wr ? 64'h0 : model[idx])) begin
          $display("FAIL data: word %0d got %h exp %h", idx, resp_data, wr ? 64'h0 : model[idx]);
          errors++;
        end
        if (wr) model[idx] = merge(model[idx], wd[beats], ws[beats]);
        beats++;
        if (beats > len || beats == abort_after + 1) done = 1'b1;
        if (beats == reset_at + 1) begin
          reset = 1'b1;
          done  = 1'b1;
        end
      end else begin
        checks++;
        if (resp_last !== 1'b0 || resp_data !== 64'h0) begin
          $display("FAIL idle_outputs: cycle %0d got last=%b data=%h exp 0/0", cyc, resp_last, resp_data);
          errors++;
        end
`ifndef BURST_RESP_STALL_EN
        checks++;
        if (cyc >= LAT + 1) begin
          $display("FAIL missing_ready: cycle %0d beat %0d got ready=0 exp 1", cyc, beats);
          errors++;
        end
`endif
      end
      @(posedge clk); #1;
      if (cyc == 0) begin
        req_addr = $urandom;
        req_len  = 4'($urandom);
      end
      if (done) req_valid = 1'b0;
      else if (beats < BN) begin
        req_data = wd[beats]; req_strobe = ws[beats];
      end
      cyc++;
    end
    checks++;
    if (!done) begin
      $display("FAIL timeout: beats=%0d exp %0d within 200 cycles", beats, len + 1);
      errors++;
    end
    total = cyc;
    if (abort_after >= 0 && reset_at < 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++;
        if (resp_ready !== 1'b0) begin
          $display("FAIL abort_ready: cycle %0d after abort got %b exp 0", k, resp_ready);
          errors++;
        end
        @(posedge clk); #1;
      end
    end
    if (reset_at >= 0) begin
      @(negedge clk);
      checks++;
      if (resp_ready !== 1'b0 || resp_last !== 1'b0 || resp_data !== 64'h0) begin
        $display("FAIL reset_mid: got ready=%b last=%b data=%h exp 0/0/0", resp_ready, resp_last, resp_data);
        errors++;
      end
      reset = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_is_write = 1'b0; req_addr = '0; req_len = '0;
    req_strobe = '0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_ready, resp_last, resp_data} !== 66'h0) begin
      $display("FAIL reset_outputs: got ready=%b last=%b data=%h exp 0/0/0", resp_ready, resp_last, resp_data);
      errors++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp_ready, resp_last, resp_data} !== 66'h0) begin
      $display("FAIL post_reset_idle: got ready=%b last=%b data=%h exp 0/0/0", resp_ready, resp_last, resp_data);
      errors++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    int t, b;
    for (int i = 0; i < MW / BN; i++)
      do_burst(1'b1, 32'(i * 128), 15, 8'hFF, 1'b0, 64'h1000 + 64'(i * 16), -1, -1, t, b);
  endtask

  task automatic test_read_burst();
    int t, b;
    do_burst(1'b0, 32'h80, 15, 8'h00, 1'b0, '0, -1, -1, t, b);
    checks++;
    if (b != 16) begin
      $display("FAIL read_beats: got %0d exp 16", b);
      errors++;
    end
    checks++;
    if (model[16] !== 64'h1010 || model[31] !== 64'h101F) begin
      $display("FAIL read_model: got %h..%h exp 1010..101f", model[16], model[31]);
      errors++;
    end
`ifdef BURST_RESP_STALL_EN
    checks++;
    if (t - (LAT + 1) <= 16) begin
      $display("FAIL stall_window: got %0d cycles exp more than 16", t - (LAT + 1));
      errors++;
    end
`else
    checks++;
    if (t - (LAT + 1) != 16) begin
      $display("FAIL read_window: got %0d cycles exp 16", t - (LAT + 1));
      errors++;
    end
`endif
  endtask

  task automatic test_write_strobe();
    int t, b;
    do_burst(1'b1, 32'h100, 3, 8'h0F, 1'b0, 64'hAAAA_0000, -1, -1, t, b);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (model[32 + i] !== {32'h0, 32'hAAAA_0000 + 32'(i)}) begin
        $display("FAIL strobe_model: word %0d got %h exp %h", 32 + i, model[32 + i], {32'h0, 32'hAAAA_0000 + 32'(i)});
        errors++;
      end
    end
    do_burst(1'b0, 32'h100, 3, 8'h00, 1'b0, '0, -1, -1, t, b);
  endtask

  task automatic test_wrap();
    int t, b;
    do_burst(1'b0, 32'(4094 << 3), 3, 8'h00, 1'b0, '0, -1, -1, t, b);
    do_burst(1'b1, 32'(4095 << 3), 2, 8'h00, 1'b1, '0, -1, -1, t, b);
    do_burst(1'b0, 32'(4094 << 3), 3, 8'h00, 1'b0, '0, -1, -1, t, b);
  endtask

  task automatic test_abort();
    int t, b;
    do_burst(1'b1, 32'h400, 7, 8'hFF, 1'b1, '0, 2, -1, t, b);
    checks++;
    if (b != 3) begin
      $display("FAIL abort_beats: got %0d exp 3", b);
      errors++;
    end
    do_burst(1'b0, 32'h400, 7, 8'h00, 1'b0, '0, -1, -1, t, b);
  endtask

  task automatic test_reset_mid();
    int t, b;
    do_burst(1'b0, 32'h200, 15, 8'h00, 1'b0, '0, -1, 5, t, b);
    do_burst(1'b0, 32'h208, 0, 8'h00, 1'b0, '0, -1, -1, t, b);
    checks++;
    if (b != 1) begin
      $display("FAIL single_beat: got %0d beats exp 1", b);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int t, b;
    for (int n = 0; n < 24; n++) begin
      do_burst(1'($urandom), $urandom, int'($urandom_range(0, BN - 1)), 8'h00, 1'b1, '0,
               -1, -1, t, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_burst();
    test_write_strobe();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
